// File: rtl/fiber_block_buffer.sv
// Single-block fiber buffer: packs a 17-bit word stream four words per SRAM line,
// then replays the stored block from SRAM as the same token stream.
module fiber_block_buffer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic                    tile_en,
    input  logic [DATA_W:0]         block_wr_in,
    input  logic                    block_wr_in_valid,
    output logic                    block_wr_in_ready,
    output logic [DATA_W:0]         block_rd_out,
    output logic                    block_rd_out_valid,
    input  logic                    block_rd_out_ready,
    output logic [ADDR_W-1:0]       addr_to_mem,
    output logic [DATA_W*LANES-1:0] data_to_mem,
    output logic                    wen_to_mem,
    output logic                    ren_to_mem,
    input  logic [DATA_W*LANES-1:0] data_from_mem
);

    localparam int TOK_W  = DATA_W + 1;
    localparam int LINE_W = DATA_W * LANES;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [TOK_W-1:0]  DONE_TOKEN = {1'b1, DATA_W'(16'h0100)};
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {W_LEN, W_DATA, W_DONE, W_WAIT} w_state_t;
    typedef enum logic [2:0] {R_IDLE, R_LEN, R_FETCH, R_LOAD, R_DATA, R_EOS} r_state_t;

    w_state_t            w_state;
    r_state_t            r_state;
    logic [DATA_W-1:0]   wr_len;
    logic [DATA_W-1:0]   wr_cnt;
    logic [DATA_W-1:0]   rd_cnt;
    logic [LINE_W-1:0]   staging;
    logic [LINE_W-1:0]   merged;
    logic [LINE_W-1:0]   rd_buf;
    logic [TOK_W-1:0]    rd_token;
    logic                rd_valid;
    logic                len_absent;
    logic                full;

    logic                active;
    logic                wr_fire;
    logic                rd_fire;
    logic                tok_ctrl;
    logic                tok_done;
    logic [DATA_W-1:0]   tok_word;
    logic [LANE_W-1:0]   wr_lane;
    logic [LANE_W-1:0]   rd_lane;
    logic [LANE_W-1:0]   rd_lane_nxt;
    logic                wr_last;
    logic                rd_last;
    logic                line_write;
    logic                blk_close;
    logic                blk_close_empty;
    logic                eos_fire;

    // A stalled or disabled tile must never see a handshake, so clk_en and flush gate it too.
    assign active   = clk_en & tile_en & ~flush;

    assign block_wr_in_ready  = active & (w_state != W_WAIT);
    assign block_rd_out_valid = active & rd_valid;
    assign block_rd_out       = rd_token;

    assign wr_fire  = block_wr_in_valid & block_wr_in_ready;
    assign rd_fire  = block_rd_out_valid & block_rd_out_ready;
    assign tok_ctrl = block_wr_in[DATA_W];
    assign tok_done = (block_wr_in == DONE_TOKEN);
    assign tok_word = block_wr_in[DATA_W-1:0];

    assign wr_lane     = wr_cnt[LANE_W-1:0];
    assign rd_lane     = rd_cnt[LANE_W-1:0];
    assign rd_lane_nxt = rd_lane + 1'b1;
    assign wr_last     = (wr_cnt == wr_len - 1'b1);
    assign rd_last     = (rd_cnt == wr_len - 1'b1);

    assign line_write = wr_fire & (w_state == W_DATA) & ~tok_ctrl &
                        ((wr_lane == LAST_LANE) | wr_last);
    assign blk_close       = wr_fire & tok_done & ((w_state == W_LEN) | (w_state == W_DONE));
    assign blk_close_empty = blk_close & (w_state == W_LEN);
    assign eos_fire        = rd_fire & (r_state == R_EOS);

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        merged = staging;
        merged[wr_lane*DATA_W +: DATA_W] = tok_word;
    end

    // The line is written in the cycle its last word arrives, so the port is driven combinationally.
    always_comb begin
        wen_to_mem  = line_write;
        ren_to_mem  = active & (r_state == R_FETCH);
        addr_to_mem = '0;
        data_to_mem = '0;
        if (line_write) begin
            addr_to_mem = wr_cnt[LANE_W +: ADDR_W];
            data_to_mem = merged;
        end else if (ren_to_mem) begin
            addr_to_mem = rd_cnt[LANE_W +: ADDR_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_LEN;
            wr_len     <= '0;
            wr_cnt     <= '0;
            staging    <= '0;
            len_absent <= 1'b0;
        end else if (flush) begin
            w_state    <= W_LEN;
            wr_len     <= '0;
            wr_cnt     <= '0;
            staging    <= '0;
            len_absent <= 1'b0;
        end else if (clk_en) begin
            case (w_state)
                W_LEN: begin
                    if (wr_fire) begin
                        if (tok_done) begin
                            len_absent <= 1'b1;
                            w_state    <= W_WAIT;
                        end else if (!tok_ctrl) begin
                            len_absent <= 1'b0;
                            wr_len     <= tok_word;
                            wr_cnt     <= '0;
                            staging    <= '0;
                            w_state    <= (tok_word == '0) ? W_DONE : W_DATA;
                        end
                    end
                end
                W_DATA: begin
                    if (wr_fire && !tok_ctrl) begin
                        wr_cnt  <= wr_cnt + 1'b1;
                        staging <= line_write ? '0 : merged;
                        if (wr_last) w_state <= W_DONE;
                    end
                end
                W_DONE: begin
                    if (wr_fire && tok_done) w_state <= W_WAIT;
                end
                W_WAIT: begin
                    if (!full) w_state <= W_LEN;
                end
                default: w_state <= W_LEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (blk_close) begin
            full <= 1'b1;
        end else if (eos_fire) begin
            full <= 1'b0;
        end
    end

    // The read side leaves idle on the same edge the block closes, saving a cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            rd_cnt   <= '0;
            rd_buf   <= '0;
            rd_token <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            r_state  <= R_IDLE;
            rd_cnt   <= '0;
            rd_buf   <= '0;
            rd_token <= '0;
            rd_valid <= 1'b0;
        end else if (clk_en && tile_en) begin
            case (r_state)
                R_IDLE: begin
                    if (blk_close) begin
                        rd_valid <= 1'b1;
                        if (blk_close_empty) begin
                            rd_token <= DONE_TOKEN;
                            r_state  <= R_EOS;
                        end else begin
                            rd_token <= {1'b0, wr_len};
                            r_state  <= R_LEN;
                        end
                    end
                end
                R_LEN: begin
                    if (rd_fire) begin
                        rd_cnt <= '0;
                        if (wr_len == '0) begin
                            rd_token <= DONE_TOKEN;
                            r_state  <= R_EOS;
                        end else begin
                            rd_valid <= 1'b0;
                            r_state  <= R_FETCH;
                        end
                    end
                end
                R_FETCH: r_state <= R_LOAD;
                R_LOAD: begin
                    rd_buf   <= data_from_mem;
                    rd_token <= {1'b0, data_from_mem[rd_lane*DATA_W +: DATA_W]};
                    rd_valid <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (rd_fire) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_last) begin
                            rd_token <= DONE_TOKEN;
                            r_state  <= R_EOS;
                        end else if (rd_lane == LAST_LANE) begin
                            rd_valid <= 1'b0;
                            r_state  <= R_FETCH;
                        end else begin
                            rd_token <= {1'b0, rd_buf[rd_lane_nxt*DATA_W +: DATA_W]};
                        end
                    end
                end
                R_EOS: begin
                    if (rd_fire) begin
                        rd_valid <= 1'b0;
                        rd_token <= '0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fiber_block_buffer.sv
// Scoreboard bench for fiber_block_buffer: directed blocks with hand-computed SRAM lines
// and read-out tokens, checked by independent monitors against queued expectations.
module tb_fiber_block_buffer;

    localparam logic [16:0] DONE = 17'h10100;

    typedef struct {
        logic [8:0]  addr;
        logic [63:0] data;
    } wr_exp_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        tile_en;
    logic [16:0] block_wr_in;
    logic        block_wr_in_valid;
    logic        block_wr_in_ready;
    logic [16:0] block_rd_out;
    logic        block_rd_out_valid;
    logic        block_rd_out_ready;
    logic [8:0]  addr_to_mem;
    logic [63:0] data_to_mem;
    logic        wen_to_mem;
    logic        ren_to_mem;
    logic [63:0] data_from_mem;

    logic [63:0] sram [0:511];

    logic [16:0] rd_q[$];
    wr_exp_t     wr_q[$];

    int checks = 0;
    int errors = 0;
    int ren_count = 0;
    int rd_mode = 0;
    time accept_time = 0;
    time last_eos_time = 0;

    fiber_block_buffer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clk_en             (clk_en),
        .flush              (flush),
        .tile_en            (tile_en),
        .block_wr_in        (block_wr_in),
        .block_wr_in_valid  (block_wr_in_valid),
        .block_wr_in_ready  (block_wr_in_ready),
        .block_rd_out       (block_rd_out),
        .block_rd_out_valid (block_rd_out_valid),
        .block_rd_out_ready (block_rd_out_ready),
        .addr_to_mem        (addr_to_mem),
        .data_to_mem        (data_to_mem),
        .wen_to_mem         (wen_to_mem),
        .ren_to_mem         (ren_to_mem),
        .data_from_mem      (data_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_rd(input logic [16:0] tok);
        rd_q.push_back(tok);
    endtask

    task automatic exp_wr(input logic [8:0] addr, input logic [63:0] data);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        wr_q.push_back(e);
    endtask

    task automatic send(input logic [16:0] tok);
        int waited;
        waited = 0;
        block_wr_in       = tok;
        block_wr_in_valid = 1'b1;
        @(negedge clk);
        while (!block_wr_in_ready && waited < 2000) begin
            waited++;
            @(negedge clk);
        end
        if (!block_wr_in_ready) fail("wr_accept_timeout");
        else accept_time = $time;
        @(posedge clk);
        #1;
        block_wr_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int waited;
        waited = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && waited < 3000) begin
            waited++;
            @(negedge clk);
        end
        check({name, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        check({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        rd_mode = m;
    endtask

    // Read-side ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = held low.
    initial begin
        block_rd_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       block_rd_out_ready = 1'b1;
                1:       block_rd_out_ready = ~block_rd_out_ready;
                default: block_rd_out_ready = 1'b0;
            endcase
        end
    end

    // Read monitor: pops on each accepted token and checks stall stability.
    initial begin
        logic        prev_stall;
        logic [16:0] prev_tok;
        prev_stall = 1'b0;
        prev_tok   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(block_rd_out_valid), 64'd1);
                    check("stall_token_held", 64'(block_rd_out), 64'(prev_tok));
                end
                if (block_rd_out_valid && block_rd_out_ready) begin
                    if (rd_q.size() == 0) begin
                        fail("rd_unexpected_token");
                    end else begin
                        check("rd_token", 64'(block_rd_out), 64'(rd_q.pop_front()));
                    end
                    if (block_rd_out == DONE) last_eos_time = $time;
                end
                prev_stall = block_rd_out_valid && !block_rd_out_ready;
                prev_tok   = block_rd_out;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Memory-port monitor: every write must match the next expected line.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ren_to_mem) ren_count++;
                if (wen_to_mem && ren_to_mem) fail("wen_ren_overlap");
                if (wen_to_mem) begin
                    if (wr_q.size() == 0) begin
                        fail("mem_unexpected_write");
                    end else begin
                        e = wr_q.pop_front();
                        check("mem_wr_addr", 64'(addr_to_mem), 64'(e.addr));
                        check("mem_wr_data", data_to_mem, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ren_before;
        rst_n             = 1'b0;
        clk_en            = 1'b1;
        flush             = 1'b0;
        tile_en           = 1'b1;
        block_wr_in       = '0;
        block_wr_in_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_rd_valid", 64'(block_rd_out_valid), 64'd0);
        check("reset_rd_token", 64'(block_rd_out), 64'd0);
        check("reset_wen", 64'(wen_to_mem), 64'd0);
        check("reset_ren", 64'(ren_to_mem), 64'd0);
        check("reset_mem_data", data_to_mem, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_wr_ready", 64'(block_wr_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic block of five words, reader always ready.
        exp_wr(9'd0, 64'h0004_0003_0002_0001);
        exp_wr(9'd1, 64'h0000_0000_0000_0005);
        exp_rd(17'h00005);
        for (int i = 1; i <= 5; i++) exp_rd(17'(i));
        exp_rd(DONE);
        ren_before = ren_count;
        send(17'h00005);
        for (int i = 1; i <= 5; i++) send(17'(i));
        send(DONE);
        @(negedge clk);
        check("len_valid_latency", 64'(block_rd_out_valid), 64'd1);
        check("len_token_first", 64'(block_rd_out), 64'h00005);
        wait_drain("blk5");
        check("blk5_ren_lines", 64'(ren_count - ren_before), 64'd2);

        // Same block with the reader stalling every other cycle.
        set_mode(1);
        exp_wr(9'd0, 64'h0004_0003_0002_0001);
        exp_wr(9'd1, 64'h0000_0000_0000_0005);
        exp_rd(17'h00005);
        for (int i = 1; i <= 5; i++) exp_rd(17'(i));
        exp_rd(DONE);
        send(17'h00005);
        for (int i = 1; i <= 5; i++) send(17'(i));
        send(DONE);
        wait_drain("blk5_toggle");
        set_mode(0);

        // Empty stream: DONE only, no SRAM traffic.
        ren_before = ren_count;
        exp_rd(DONE);
        send(DONE);
        @(negedge clk);
        check("empty_done_latency", 64'(block_rd_out), 64'(DONE));
        wait_drain("empty");
        check("empty_ren_lines", 64'(ren_count - ren_before), 64'd0);

        // Two back-to-back blocks; the second must wait for the first DONE to be read.
        set_mode(2);
        exp_wr(9'd0, 64'h0103_0102_0101_0100);
        exp_wr(9'd1, 64'h0107_0106_0105_0104);
        exp_rd(17'h00008);
        for (int i = 0; i < 8; i++) exp_rd(17'h00100 + 17'(i));
        exp_rd(DONE);
        send(17'h00008);
        for (int i = 0; i < 8; i++) send(17'h00100 + 17'(i));
        send(DONE);
        repeat (10) @(negedge clk);
        check("blocked_wr_ready", 64'(block_wr_in_ready), 64'd0);
        check("blocked_len_pending", 64'(block_rd_out), 64'h00008);
        set_mode(0);
        exp_wr(9'd0, 64'h0000_000C_000B_000A);
        exp_rd(17'h00003);
        exp_rd(17'h0000A);
        exp_rd(17'h0000B);
        exp_rd(17'h0000C);
        exp_rd(DONE);
        send(17'h00003);
        check("second_after_first_eos", 64'(accept_time > last_eos_time), 64'd1);
        send(17'h0000A);
        send(17'h0000B);
        send(17'h0000C);
        send(DONE);
        wait_drain("two_blocks");

        // Flush abandons a partly written block.
        send(17'h00006);
        send(17'h00021);
        send(17'h00022);
        flush = 1'b1;
        @(negedge clk);
        check("flush_wr_ready", 64'(block_wr_in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_wr(9'd0, 64'h0000_0000_0008_0007);
        exp_rd(17'h00002);
        exp_rd(17'h00007);
        exp_rd(17'h00008);
        exp_rd(DONE);
        send(17'h00002);
        send(17'h00007);
        send(17'h00008);
        send(DONE);
        wait_drain("flush");

        // tile_en low blocks a line-completing word until re-enabled.
        exp_wr(9'd0, 64'h0000_0000_0000_0055);
        exp_rd(17'h00001);
        exp_rd(17'h00055);
        exp_rd(DONE);
        send(17'h00001);
        tile_en           = 1'b0;
        block_wr_in       = 17'h00055;
        block_wr_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tile_off_wr_ready", 64'(block_wr_in_ready), 64'd0);
            check("tile_off_wen", 64'(wen_to_mem), 64'd0);
        end
        @(posedge clk);
        #1;
        tile_en = 1'b1;
        send(17'h00055);
        send(DONE);
        wait_drain("tile_en");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fiber_block_buffer.md
Name: fiber_block_buffer

Overview:
- Block-mode fiber access unit for the sparse-tile datapath.
- It accepts one block of 16-bit words from the global buffer over a 17-bit ready/valid stream and packs the words four per 64-bit line into an external single-port SRAM.
- Once the block is complete, it reads the block back and replays it as the same 17-bit stream toward the global buffer.
- It holds a single block buffer, so the write and read phases alternate.

Parameters:
- ADDR_W, 9, SRAM line address width (512 lines).
- DATA_W, 16, data word width; the token width is DATA_W+1.
- LANES, 4, words per 64-bit SRAM line.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  when 0, all state holds and mem enables are 0
- flush  in  1  synchronous soft reset to idle
- tile_en  in  1  when 0, readies, valids and mem enables are forced to 0
- block_wr_in  in  17  write token; bit16=1 marks a control token
- block_wr_in_valid  in  1  write token valid
- block_wr_in_ready  out  1  write token ready
- block_rd_out  out  17  read token
- block_rd_out_valid  out  1  read token valid
- block_rd_out_ready  in  1  read token ready
- addr_to_mem  out  9  SRAM line address
- data_to_mem  out  64  SRAM write data
- wen_to_mem  out  1  SRAM write enable
- ren_to_mem  out  1  SRAM read enable
- data_from_mem  in  64  SRAM read data, valid the cycle after ren

Behaviour:
- A token transfers on a clock edge when valid and ready are both high.
- DONE token = 0x10100; any other token with bit16=1 is ignored (consumed, no effect).
- Reset (rst_n=0) or flush:
  - write FSM goes to W_LEN and read FSM goes to R_IDLE;
  - full flag, counters and staging register are cleared;
  - all valid and mem enable outputs are 0; data outputs are 0.
- Write FSM:
  - W_LEN: ready=1. A data token latches N = token[15:0] and the FSM goes to W_DATA, or to W_DONE if N=0. A DONE token here means an empty stream: the FSM goes directly to FULL with N marked absent.
  - W_DATA: ready=1. Word i (0-based) goes into staging lane i%4, bits [16*(i%4)+15 : 16*(i%4)].
    - When lane 3 fills, or i=N-1, the line is written in the same cycle: wen=1, addr=i/4, data = staging with the new word merged, unfilled lanes 0.
    - The staging register is then cleared.
    - After word N-1 the FSM goes to W_DONE.
  - W_DONE: ready=1. It waits for the DONE token, sets full, and goes to W_WAIT.
  - W_WAIT: ready=0 until the read FSM clears full, then returns to W_LEN.
- Address arithmetic is 9-bit and wraps modulo 512 lines; N > 2048 therefore overwrites earlier lines. The bench only uses N ≤ 2048.
- Read FSM:
  - R_IDLE: waits for full.
  - R_LEN: drives N (bit16=0), or DONE directly if the stream was empty.
  - R_FETCH: ren=1 with addr = line index; goes to R_LOAD.
  - R_LOAD: captures data_from_mem into a 64-bit buffer.
  - R_DATA: drives lane j = word%4. Each accepted word advances the counter. Lane 3, or the last word, moves to R_FETCH for the next line, or to R_EOS after word N-1.
  - R_EOS: drives DONE. On acceptance it clears full and returns to R_IDLE.
  - All read outputs are held stable while ready is low.
- Latency:
  - block_rd_out_valid (length token) rises on the 1st cycle after the DONE token is accepted.
  - Each new line costs 2 bubble cycles (fetch + load).
- Memory port: writes occur only in W_DATA and reads only in R_FETCH, so there is never a simultaneous wen and ren.
- Flush or reset mid-operation abandons the current block; SRAM contents are not cleared.

Test Plan:
- Write 0x0005, 1,2,3,4,5, DONE with rd ready=1 → two writes:
  - line 0 = 0x0004_0003_0002_0001;
  - line 1 = 0x0000_0000_0000_0005.
  - Read-out is 0x00005, 1,2,3,4,5, 0x10100.
- Same block with rd ready toggling 1/0 every cycle → identical token sequence; no duplicated or dropped tokens; outputs stable while stalled.
- Empty stream (DONE only) → no SRAM activity; read-out is 0x10100 only.
- Block N=8, then a second block N=3 (10,11,12) → the second block's write is not accepted until the first DONE is read. Outputs:
  - first block: 8 words;
  - second block: 0x00003, 10,11,12, 0x10100.
- Assert flush after 2 data words of an N=6 block, then send N=2 (7,8), DONE → read-out is 0x00002, 7,8, 0x10100.
- Hold tile_en=0 with a valid write token → block_wr_in_ready=0, wen=0; the transfer proceeds normally once tile_en=1.
